mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; consumes its register-write result and its RAM request (we/re, word address, byte mask, pre-swapped write data, sign-extend flag).
- Drives the word-addressed data BRAM and formats load data back to little-endian with sign/zero extension.
- Presents one write-back beat per instruction.
- Stalls upstream with a valid/ready handshake while a load is outstanding for the BRAM read latency.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_stage_load_formatter.sv | 45 ++++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: the default BRAM address width,
// byte-lane mask encodings, FSM state encoding and a load-mask legality helper.
package mem_stage_pkg;

    // Word-address width of the data BRAM used across the pipeline
    localparam int SHARED_MEM_ADDR_WIDTH = 10;

    // Byte-lane masks; bit3 selects lane [31:24], which holds the lowest address
    localparam logic [3:0] MASK_NONE  = 4'b0000;
    localparam logic [3:0] MASK_WORD  = 4'b1111;
    localparam logic [3:0] MASK_HALF0 = 4'b1100;
    localparam logic [3:0] MASK_HALF1 = 4'b0011;
    localparam logic [3:0] MASK_BYTE0 = 4'b1000;
    localparam logic [3:0] MASK_BYTE1 = 4'b0100;
    localparam logic [3:0] MASK_BYTE2 = 4'b0010;
    localparam logic [3:0] MASK_BYTE3 = 4'b0001;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    // True for the word, halfword and byte masks a load may use
    function automatic logic isLoadMaskLegal(input logic [3:0] mask);
        case (mask)
            MASK_WORD, MASK_HALF0, MASK_HALF1,
            MASK_BYTE0, MASK_BYTE1, MASK_BYTE2, MASK_BYTE3: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Turns a byte-lane ordered BRAM word into a little-endian register value,
// selecting the lanes named by the mask and sign- or zero-extending them.
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [3:0]  i_mask,
    input  logic        i_sign_ext,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result,
    output logic        o_illegal
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane selection and byte swap, with extension for sub-word loads
    always_comb begin
        w_half    = '0;
        w_byte    = '0;
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_mask)
            MASK_WORD: o_result = {i_rdata[7:0], i_rdata[15:8], i_rdata[23:16], i_rdata[31:24]};
            MASK_HALF0: begin
                w_half   = {i_rdata[23:16], i_rdata[31:24]};
                o_result = {{16{i_sign_ext & w_half[15]}}, w_half};
            end
            MASK_HALF1: begin
                w_half   = {i_rdata[7:0], i_rdata[15:8]};
                o_result = {{16{i_sign_ext & w_half[15]}}, w_half};
            end
            MASK_BYTE0, MASK_BYTE1, MASK_BYTE2, MASK_BYTE3: begin
                case (i_mask)
                    MASK_BYTE0: w_byte = i_rdata[31:24];
                    MASK_BYTE1: w_byte = i_rdata[23:16];
                    MASK_BYTE2: w_byte = i_rdata[15:8];
                    default:    w_byte = i_rdata[7:0];
                endcase
                o_result = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues BRAM requests for the execute stage, stalls
// while a load is in flight, and produces one write-back beat per instruction.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = SHARED_MEM_ADDR_WIDTH,
    parameter int READ_LATENCY   = 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_rd_we,
    input  logic [4:0]                ex_rd_addr,
    input  logic [31:0]               ex_rd_data,
    input  logic                      ex_ram_we,
    input  logic                      ex_ram_re,
    input  logic [MEM_ADDR_WIDTH-1:0] ex_ram_addr,
    input  logic [31:0]               ex_ram_wdata,
    input  logic [3:0]                ex_ram_mask,
    input  logic                      ex_ram_sign_ext,
    output logic                      bram_en,
    output logic [3:0]                bram_we,
    output logic [MEM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]               bram_wdata,
    input  logic [31:0]               bram_rdata,
    output logic                      wb_valid,
    output logic                      wb_rd_we,
    output logic [4:0]                wb_rd_addr,
    output logic [31:0]               wb_rd_data,
    output logic                      misalign
);

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_count;
    logic [4:0]  r_rdAddr;
    logic        r_rdWe;
    logic [3:0]  r_mask;
    logic        r_signExt;
    logic        w_accept;
    logic        w_isStore;
    logic        w_isLoad;
    logic [31:0] w_fmtResult;
    logic        w_fmtIllegal;

    // A simultaneous read and write is handled purely as a store
    assign w_accept  = ex_valid && (r_state == ST_IDLE);
    assign w_isStore = ex_ram_we;
    assign w_isLoad  = ex_ram_re && !ex_ram_we;

    load_formatter u_fmt (
        .i_mask     (r_mask),
        .i_sign_ext (r_signExt),
        .i_rdata    (bram_rdata),
        .o_result   (w_fmtResult),
        .o_illegal  (w_fmtIllegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state, handshake and BRAM request decode
    always_comb begin
        w_nextState = r_state;
        ex_ready    = (r_state == ST_IDLE);
        bram_en     = 1'b0;
        bram_we     = '0;
        bram_addr   = ex_ram_addr;
        bram_wdata  = ex_ram_wdata;
        misalign    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    bram_en  = w_isStore || w_isLoad;
                    bram_we  = w_isStore ? ex_ram_mask : 4'b0000;
                    misalign = (w_isStore && (ex_ram_mask == MASK_NONE)) ||
                               (w_isLoad && !isLoadMaskLegal(ex_ram_mask));
                    if (w_isLoad) w_nextState = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (r_count == 2'd1) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Load bookkeeping, latency countdown and write-back registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_rdAddr   <= '0;
            r_rdWe     <= 1'b0;
            r_mask     <= '0;
            r_signExt  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd_we   <= 1'b0;
            wb_rd_addr <= '0;
            wb_rd_data <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (w_accept) begin
                if (w_isLoad) begin
                    r_rdAddr  <= ex_rd_addr;
                    r_rdWe    <= ex_rd_we;
                    r_mask    <= ex_ram_mask;
                    r_signExt <= ex_ram_sign_ext;
                    r_count   <= LAT_INIT;
                end else begin
                    wb_valid   <= 1'b1;
                    wb_rd_addr <= ex_rd_addr;
                    wb_rd_we   <= !w_isStore && ex_rd_we && (ex_rd_addr != 5'd0);
                    wb_rd_data <= w_isStore ? 32'd0 : ex_rd_data;
                end
            end else if (r_state == ST_LOAD_WAIT) begin
                if (r_count == 2'd1) begin
                    wb_valid   <= 1'b1;
                    wb_rd_addr <= r_rdAddr;
                    wb_rd_we   <= r_rdWe && !w_fmtIllegal && (r_rdAddr != 5'd0);
                    wb_rd_data <= w_fmtResult;
                end else begin
                    r_count <= r_count - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table on a READ_LATENCY=1 instance with a
// write-back scoreboard, plus hand sequences on a READ_LATENCY=3 instance.
module tb_mem_stage;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          exValid1, exValid3;
    logic          exRdWe;
    logic [4:0]    exRdAddr;
    logic [31:0]   exRdData;
    logic          exRamWe, exRamRe;
    logic [AW-1:0] exRamAddr;
    logic [31:0]   exRamWdata;
    logic [3:0]    exRamMask;
    logic          exRamSext;
    logic [31:0]   bramRdata;

    logic          exReady1, bramEn1, wbValid1, wbRdWe1, misalign1;
    logic [3:0]    bramWe1;
    logic [AW-1:0] bramAddr1;
    logic [31:0]   bramWdata1, wbRdData1;
    logic [4:0]    wbRdAddr1;

    logic          exReady3, bramEn3, wbValid3, wbRdWe3, misalign3;
    logic [3:0]    bramWe3;
    logic [AW-1:0] bramAddr3;
    logic [31:0]   bramWdata3, wbRdData3;
    logic [4:0]    wbRdAddr3;

    mem_stage #(.MEM_ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ex_valid(exValid1), .ex_ready(exReady1),
        .ex_rd_we(exRdWe), .ex_rd_addr(exRdAddr), .ex_rd_data(exRdData),
        .ex_ram_we(exRamWe), .ex_ram_re(exRamRe), .ex_ram_addr(exRamAddr),
        .ex_ram_wdata(exRamWdata), .ex_ram_mask(exRamMask), .ex_ram_sign_ext(exRamSext),
        .bram_en(bramEn1), .bram_we(bramWe1), .bram_addr(bramAddr1), .bram_wdata(bramWdata1),
        .bram_rdata(bramRdata), .wb_valid(wbValid1), .wb_rd_we(wbRdWe1),
        .wb_rd_addr(wbRdAddr1), .wb_rd_data(wbRdData1), .misalign(misalign1)
    );

    mem_stage #(.MEM_ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ex_valid(exValid3), .ex_ready(exReady3),
        .ex_rd_we(exRdWe), .ex_rd_addr(exRdAddr), .ex_rd_data(exRdData),
        .ex_ram_we(exRamWe), .ex_ram_re(exRamRe), .ex_ram_addr(exRamAddr),
        .ex_ram_wdata(exRamWdata), .ex_ram_mask(exRamMask), .ex_ram_sign_ext(exRamSext),
        .bram_en(bramEn3), .bram_we(bramWe3), .bram_addr(bramAddr3), .bram_wdata(bramWdata3),
        .bram_rdata(bramRdata), .wb_valid(wbValid3), .wb_rd_we(wbRdWe3),
        .wb_rd_addr(wbRdAddr3), .wb_rd_data(wbRdData3), .misalign(misalign3)
    );

    typedef struct {
        logic        rdWe;
        logic [4:0]  rdAddr;
        logic [31:0] rdData;
        int          due;
    } WbExp_t;

    typedef struct {
        logic        rdWe;
        logic [4:0]  rdAddr;
        logic [31:0] rdData;
        logic        ramWe;
        logic        ramRe;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        sext;
        logic [31:0] rdata;
        logic        expEn;
        logic [3:0]  expWe;
        logic        expMis;
        logic        expWbWe;
        logic [31:0] expWbData;
    } Vec_t;

    localparam int NVEC = 18;
    Vec_t   vecs [NVEC];
    WbExp_t expQ [$];
    WbExp_t monEntry;
    int     cycle = 0;
    int     checks = 0;
    int     errors = 0;
    bit     monitorOn = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to time write-back beats
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Scoreboard: every write-back beat of the latency-1 instance must match the queue head
    always @(negedge clk) begin
        if (monitorOn) begin
            if (wbValid1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_wb: got wb_valid=1, expected none (cycle %0d)", cycle);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("wb_cycle", cycle, monEntry.due);
                    checkOutput("wb_rd_we", {31'd0, wbRdWe1}, {31'd0, monEntry.rdWe});
                    checkOutput("wb_rd_addr", {27'd0, wbRdAddr1}, {27'd0, monEntry.rdAddr});
                    checkOutput("wb_rd_data", wbRdData1, monEntry.rdData);
                end
            end else if (expQ.size() > 0 && expQ[0].due < cycle) begin
                monEntry = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_wb: got no beat, expected data %h at cycle %0d", monEntry.rdData, monEntry.due);
            end
        end
    end

    task automatic applyStimulus(input Vec_t v);
        int     waitCnt;
        WbExp_t e;
        waitCnt = 0;
        while (!exReady1 && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!exReady1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: got ex_ready=0, expected 1 within 10 cycles");
            return;
        end
        exRdWe     = v.rdWe;
        exRdAddr   = v.rdAddr;
        exRdData   = v.rdData;
        exRamWe    = v.ramWe;
        exRamRe    = v.ramRe;
        exRamAddr  = v.addr;
        exRamWdata = v.wdata;
        exRamMask  = v.mask;
        exRamSext  = v.sext;
        bramRdata  = v.rdata;
        exValid1   = 1'b1;
        e.rdWe   = v.expWbWe;
        e.rdAddr = v.rdAddr;
        e.rdData = v.expWbData;
        e.due    = (v.ramRe && !v.ramWe) ? cycle + 2 : cycle + 1;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput("bram_en", {31'd0, bramEn1}, {31'd0, v.expEn});
        checkOutput("bram_we", {28'd0, bramWe1}, {28'd0, v.expWe});
        checkOutput("misalign", {31'd0, misalign1}, {31'd0, v.expMis});
        if (v.expEn) begin
            checkOutput("bram_addr", {22'd0, bramAddr1}, {22'd0, v.addr});
            checkOutput("bram_wdata", bramWdata1, v.wdata);
        end
        @(posedge clk); #1;
        exValid1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // rdWe rd data ramWe ramRe addr wdata mask sext rdata | en we mis wbWe wbData
        vecs[0]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 1'b0, 10'h000, 32'h0, 4'b0000, 1'b0, 32'h0,
                     1'b0, 4'b0000, 1'b0, 1'b1, 32'h12345678};
        vecs[1]  = '{1'b0, 5'd0,  32'h0, 1'b1, 1'b0, 10'h010, 32'hEFBEADDE, 4'b1111, 1'b0, 32'h0,
                     1'b1, 4'b1111, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd7,  32'h0, 1'b0, 1'b1, 10'h010, 32'h0, 4'b1111, 1'b0, 32'hEFBEADDE,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd8,  32'h0, 1'b0, 1'b1, 10'h011, 32'h0, 4'b0010, 1'b1, 32'h00008000,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'hFFFFFF80};
        vecs[4]  = '{1'b1, 5'd8,  32'h0, 1'b0, 1'b1, 10'h011, 32'h0, 4'b0010, 1'b0, 32'h00008000,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'h00000080};
        vecs[5]  = '{1'b1, 5'd9,  32'h0, 1'b0, 1'b1, 10'h012, 32'h0, 4'b0000, 1'b1, 32'h12345678,
                     1'b1, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 5'd0,  32'h0, 1'b0, 1'b1, 10'h013, 32'h0, 4'b1111, 1'b0, 32'h11223344,
                     1'b1, 4'b0000, 1'b0, 1'b0, 32'h44332211};
        vecs[7]  = '{1'b1, 5'd3,  32'hCAFEF00D, 1'b0, 1'b0, 10'h000, 32'h0, 4'b0000, 1'b0, 32'h0,
                     1'b0, 4'b0000, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[8]  = '{1'b0, 5'd0,  32'h0, 1'b1, 1'b0, 10'h3FF, 32'h00000001, 4'b0000, 1'b0, 32'h0,
                     1'b1, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 5'd4,  32'h99999999, 1'b1, 1'b1, 10'h020, 32'hA1B2C3D4, 4'b1100, 1'b0, 32'h0,
                     1'b1, 4'b1100, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 5'd10, 32'h0, 1'b0, 1'b1, 10'h021, 32'h0, 4'b1100, 1'b1, 32'h34F20000,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'hFFFFF234};
        vecs[11] = '{1'b1, 5'd11, 32'h0, 1'b0, 1'b1, 10'h022, 32'h0, 4'b0011, 1'b0, 32'h0000F281,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'h000081F2};
        vecs[12] = '{1'b1, 5'd12, 32'h0, 1'b0, 1'b1, 10'h023, 32'h0, 4'b0001, 1'b1, 32'h0000007F,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'h0000007F};
        vecs[13] = '{1'b1, 5'd13, 32'h0, 1'b0, 1'b1, 10'h024, 32'h0, 4'b1000, 1'b1, 32'hA5000000,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFA5};
        vecs[14] = '{1'b1, 5'd14, 32'h0, 1'b0, 1'b1, 10'h025, 32'h0, 4'b0100, 1'b0, 32'h00C30000,
                     1'b1, 4'b0000, 1'b0, 1'b1, 32'h000000C3};
        vecs[15] = '{1'b1, 5'd15, 32'h0, 1'b0, 1'b1, 10'h026, 32'h0, 4'b0110, 1'b1, 32'hFFFFFFFF,
                     1'b1, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[16] = '{1'b1, 5'd0,  32'h55AA55AA, 1'b0, 1'b0, 10'h000, 32'h0, 4'b0000, 1'b0, 32'h0,
                     1'b0, 4'b0000, 1'b0, 1'b0, 32'h55AA55AA};
        vecs[17] = '{1'b0, 5'd6,  32'h00000001, 1'b0, 1'b0, 10'h000, 32'h0, 4'b0000, 1'b0, 32'h0,
                     1'b0, 4'b0000, 1'b0, 1'b0, 32'h00000001};

        rst = 1'b1;
        exValid1 = 1'b0; exValid3 = 1'b0;
        exRdWe = 1'b0; exRdAddr = '0; exRdData = '0;
        exRamWe = 1'b0; exRamRe = 1'b0; exRamAddr = '0; exRamWdata = '0;
        exRamMask = '0; exRamSext = 1'b0; bramRdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ex_ready", {31'd0, exReady1}, 32'd1);
        checkOutput("rst_wb_valid", {31'd0, wbValid1}, 32'd0);
        checkOutput("rst_wb_rd_we", {31'd0, wbRdWe1}, 32'd0);
        checkOutput("rst_wb_rd_addr", {27'd0, wbRdAddr1}, 32'd0);
        checkOutput("rst_wb_rd_data", wbRdData1, 32'd0);
        checkOutput("rst_bram_en", {31'd0, bramEn1}, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign1}, 32'd0);
        checkOutput("rst_ex_ready3", {31'd0, exReady3}, 32'd1);

        $display("[TB] vector table on READ_LATENCY=1");
        monitorOn = 1'b1;
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 32'd0);
        monitorOn = 1'b0;

        $display("[TB] READ_LATENCY=3 load");
        checkOutput("rl3_ready_idle", {31'd0, exReady3}, 32'd1);
        exRdWe = 1'b1; exRdAddr = 5'd2; exRamWe = 1'b0; exRamRe = 1'b1;
        exRamAddr = 10'h040; exRamMask = 4'b1111; exRamSext = 1'b0;
        bramRdata = 32'h01020304;
        exValid3 = 1'b1;
        @(negedge clk);
        checkOutput("rl3_bram_en", {31'd0, bramEn3}, 32'd1);
        @(posedge clk); #1;
        exValid3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checkOutput("rl3_stall_ready", {31'd0, exReady3}, 32'd0);
            checkOutput("rl3_stall_wb_valid", {31'd0, wbValid3}, 32'd0);
            @(posedge clk); #1;
        end
        checkOutput("rl3_wb_valid", {31'd0, wbValid3}, 32'd1);
        checkOutput("rl3_wb_rd_data", wbRdData3, 32'h04030201);
        checkOutput("rl3_wb_rd_we", {31'd0, wbRdWe3}, 32'd1);
        checkOutput("rl3_wb_rd_addr", {27'd0, wbRdAddr3}, 32'd2);
        checkOutput("rl3_ready_back", {31'd0, exReady3}, 32'd1);
        @(posedge clk); #1;
        checkOutput("rl3_wb_pulse", {31'd0, wbValid3}, 32'd0);

        $display("[TB] READ_LATENCY=3 load abandoned by reset");
        exRdAddr = 5'd13;
        bramRdata = 32'hA5A5A5A5;
        exValid3 = 1'b1;
        @(posedge clk); #1;
        exValid3 = 1'b0;
        checkOutput("rstload_stall_ready", {31'd0, exReady3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("rstload_no_wb", {31'd0, wbValid3}, 32'd0);
            checkOutput("rstload_ready", {31'd0, exReady3}, 32'd1);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
